mux4: RTL and testbench
=======================

// Module: mux4
// PURPOSE
//   Registered 4:1 multiplexer, the operand/result select primitive of the ALU datapath.
//   Picks one of four equal-width data inputs (d0..d3) using a 2-bit select.
//   Drives the choice onto z through one output register.
//   Sits between the functional units and the ALU result register/bus.
// PARAMETERS
//   WIDTH     1   bit width of d0..d3 and z (must be >= 1)
// PORTS
//   clk    in   1      single clock; all state updates on rising edge
//   rst_n  in   1      reset, synchronous, active-low
//   d0     in   WIDTH  data input, selected when sel == 2'b00
//   d1     in   WIDTH  data input, selected when sel == 2'b01
//   d2     in   WIDTH  data input, selected when sel == 2'b10
//   d3     in   WIDTH  data input, selected when sel == 2'b11
//   sel    in   2      select; sel[1] is MSB, sel[0] is LSB
//   z      out  WIDTH  registered selected data
// BEHAVIOUR
//   - One clock (clk), rising-edge only; reset synchronous, active-low (rst_n). No async paths.
//   - Reset: at a rising clk edge with rst_n == 0, z <= '0.
//     - Reset has priority over data.
//     - Reset asserted mid-stream clears z at that same edge; prior data is discarded.
//   - Normal operation: at a rising clk edge with rst_n == 1, z <= d[sel].
//     - d[sel] is the value of d0..d3 and sel sampled at that edge.
//   - Latency is exactly 1 cycle. Throughput is 1 selection per cycle; there is no handshake.
//   - Select decode is full; all 4 codes are legal, with no default/illegal case.
//     - 00 -> d0, 01 -> d1, 10 -> d2, 11 -> d3.
//   - sel and data may change every cycle independently. Only values at the sampling edge matter.
//   - Between edges z holds; glitches on d*/sel never reach z.
//   - Bit-wise: z[i] depends only on d0[i]..d3[i] and sel; there are no cross-bit effects.
//   - After release of rst_n, the first valid z appears 1 edge after rst_n is sampled high.
//   - Combinational select uses a 2-level tree:
//     - level 1: sel[0] picks d0/d1 and d2/d3
//     - level 2: sel[1] picks between the level-1 results
//   - No latches; every combinational path is fully assigned.
// STRUCTURE
//   - Shared package mux4_pkg:
//     - typedef logic [1:0] mux4_sel_t
//     - localparams SEL_D0=2'b00, SEL_D1=2'b01, SEL_D2=2'b10, SEL_D3=2'b11
//   - Sub-module mux2 (parameter WIDTH; ports a, b, s, y; y = s ? b : a; purely combinational).
//     - Instantiate 3 times:
//       - lo: d0/d1 on sel[0]
//       - hi: d2/d3 on sel[0]
//       - top: lo/hi on sel[1]
//   - One always_ff block holds the output register z with the synchronous reset.
//   - Elaboration-time check: WIDTH >= 1, else $error.
// TESTING
//   1. Reset: rst_n=0 for 2 edges with d3..d0=1,1,1,1, sel=11 -> z==0 after each edge.
//   2. d3..d0=1,1,1,0, sel=00, one edge -> z==0.
//      Change d0=1 -> next edge z==1.
//      Restore d0=0 -> next edge z==0.
//   3. Select sweep with one-hot data:
//      - d3..d0 = 0,0,0,1: sel=00 -> z==1
//      - data shifted to d1, sel=01 -> z==1
//      - same for d2/sel=10 and d3/sel=11
//      - every unselected one-hot position -> z==0
//   4. Latency check: toggle sel between edges, with d3..d0=1,0,1,0.
//      - z reflects only the sel sampled at the prior edge, 1-cycle delay.
//      - sel=00 -> 0, then 01 -> 1
//   5. Mid-stream reset: z==1 (sel=01, d1=1), then rst_n=0 for 1 edge -> z==0.
//      Then rst_n=1 -> z==1 at the following edge.
//   6. WIDTH=8, d0=8'h11, d1=8'h22, d2=8'h44, d3=8'h88.
//      - sel 00,01,10,11 on consecutive edges -> z 11,22,44,88, lagging 1 cycle.
//      - compare every cycle against a reference model.

Source files
------------

// File: rtl/mux4_pkg.sv
// Shared types and select codes for the registered 4:1 multiplexer.
package mux4_pkg;

  typedef logic [1:0] mux4_sel_t;

  localparam mux4_sel_t SEL_D0 = 2'b00;
  localparam mux4_sel_t SEL_D1 = 2'b01;
  localparam mux4_sel_t SEL_D2 = 2'b10;
  localparam mux4_sel_t SEL_D3 = 2'b11;

endpackage

// File: rtl/mux4_mux2.sv
// Purely combinational 2:1 multiplexer, the leaf cell of the mux4 select tree.
module mux2 #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  assign y = s ? b : a;

endmodule

// File: rtl/mux4.sv
// Registered 4:1 multiplexer: two-level mux2 tree feeding one output register.
module mux4
  import mux4_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  mux4_sel_t        sel,
  output logic [WIDTH-1:0] z
);

  if (WIDTH < 1) begin : g_width_check
    $error("mux4: WIDTH must be >= 1, got %0d", WIDTH);
  end

  logic [WIDTH-1:0] lo_y;
  logic [WIDTH-1:0] hi_y;
  logic [WIDTH-1:0] sel_y;

  // sel[0] picks within each pair, sel[1] picks between the pairs
  mux2 #(.WIDTH(WIDTH)) lo  (.a(d0),   .b(d1),   .s(sel[0]), .y(lo_y));
  mux2 #(.WIDTH(WIDTH)) hi  (.a(d2),   .b(d3),   .s(sel[0]), .y(hi_y));
  mux2 #(.WIDTH(WIDTH)) top (.a(lo_y), .b(hi_y), .s(sel[1]), .y(sel_y));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      z <= '0;
    end else begin
      z <= sel_y;
    end
  end

endmodule

// File: tb/tb_mux4.sv
// Scoreboard bench for mux4: a 1-bit and an 8-bit instance, directed vectors.
module tb_mux4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       n_d0, n_d1, n_d2, n_d3;
  logic [1:0] n_sel;
  logic       n_z;
  logic [7:0] w_d0, w_d1, w_d2, w_d3;
  logic [1:0] w_sel;
  logic [7:0] w_z;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    bit         wide;
    logic [7:0] exp;
    logic       rst;
    logic [7:0] d0, d1, d2, d3;
    logic [1:0] sel;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  sb_entry_t mon_e;
  logic [7:0] mon_act;
  logic [7:0] mon_ref;

  always #5 clk = ~clk;

  mux4 #(.WIDTH(1)) dut_n (
    .clk(clk), .rst_n(rst_n),
    .d0(n_d0), .d1(n_d1), .d2(n_d2), .d3(n_d3),
    .sel(n_sel), .z(n_z)
  );

  mux4 #(.WIDTH(8)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .d0(w_d0), .d1(w_d1), .d2(w_d2), .d3(w_d3),
    .sel(w_sel), .z(w_z)
  );

  function automatic logic [7:0] ref_mux(input logic rst, input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c, input logic [7:0] d, input logic [1:0] s);
    if (!rst) return 8'h00;
    case (s)
      2'b00:   return a;
      2'b01:   return b;
      2'b10:   return c;
      default: return d;
    endcase
  endfunction

  // Narrow-instance vector: data given as {d3,d2,d1,d0}; expected z after the next edge.
  task automatic applyStimulus(input string name, input logic rst, input logic [3:0] d,
                               input logic [1:0] s, input logic exp);
    sb_entry_t e;
    @(negedge clk);
    rst_n = rst;
    {n_d3, n_d2, n_d1, n_d0} = d;
    n_sel = s;
    e.name = name; e.wide = 1'b0; e.exp = {7'b0, exp}; e.rst = rst;
    e.d0 = {7'b0, d[0]}; e.d1 = {7'b0, d[1]}; e.d2 = {7'b0, d[2]}; e.d3 = {7'b0, d[3]};
    e.sel = s;
    sb_q.push_back(e);
  endtask

  task automatic applyWide(input string name, input logic [1:0] s, input logic [7:0] exp);
    sb_entry_t e;
    @(negedge clk);
    rst_n = 1'b1;
    w_sel = s;
    e.name = name; e.wide = 1'b1; e.exp = exp; e.rst = 1'b1;
    e.d0 = w_d0; e.d1 = w_d1; e.d2 = w_d2; e.d3 = w_d3; e.sel = s;
    sb_q.push_back(e);
  endtask

  // Monitor: one scoreboard entry per rising edge, sampled just after it.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      mon_act = mon_e.wide ? w_z : {7'b0, n_z};
      checks++;
      if (mon_act !== mon_e.exp) begin
        errors++;
        $display("[TB] FAIL %s: z=%h expected %h", mon_e.name, mon_act, mon_e.exp);
      end
      if (mon_e.wide) begin
        mon_ref = ref_mux(mon_e.rst, mon_e.d0, mon_e.d1, mon_e.d2, mon_e.d3, mon_e.sel);
        checks++;
        if (w_z !== mon_ref) begin
          errors++;
          $display("[TB] FAIL %s_model: z=%h model %h", mon_e.name, w_z, mon_ref);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    {n_d3, n_d2, n_d1, n_d0} = 4'b0000;
    n_sel = 2'b00;
    w_d0 = 8'h11; w_d1 = 8'h22; w_d2 = 8'h44; w_d3 = 8'h88;
    w_sel = 2'b00;

    applyStimulus("reset_edge1", 1'b0, 4'b1111, 2'b11, 1'b0);
    applyStimulus("reset_edge2", 1'b0, 4'b1111, 2'b11, 1'b0);

    applyStimulus("d0_low",      1'b1, 4'b1110, 2'b00, 1'b0);
    applyStimulus("d0_high",     1'b1, 4'b1111, 2'b00, 1'b1);
    applyStimulus("d0_restored", 1'b1, 4'b1110, 2'b00, 1'b0);

    for (int p = 0; p < 4; p++) begin
      for (int s = 0; s < 4; s++) begin
        applyStimulus($sformatf("onehot_d%0d_sel%0d", p, s), 1'b1,
                      4'(1 << p), 2'(s), (s == p) ? 1'b1 : 1'b0);
      end
    end

    applyStimulus("latency_sel00", 1'b1, 4'b1010, 2'b00, 1'b0);
    applyStimulus("latency_sel01", 1'b1, 4'b1010, 2'b01, 1'b1);
    applyStimulus("latency_sel10", 1'b1, 4'b1010, 2'b10, 1'b0);
    // sel glitches to 11 mid-cycle but settles to 00 before the edge
    applyStimulus("glitch_sel", 1'b1, 4'b1010, 2'b11, 1'b0);
    #2 n_sel = 2'b00;

    applyStimulus("mid_pre",     1'b1, 4'b0010, 2'b01, 1'b1);
    applyStimulus("mid_reset",   1'b0, 4'b0010, 2'b01, 1'b0);
    applyStimulus("mid_release", 1'b1, 4'b0010, 2'b01, 1'b1);

    applyWide("wide_sel00", 2'b00, 8'h11);
    applyWide("wide_sel01", 2'b01, 8'h22);
    applyWide("wide_sel10", 2'b10, 8'h44);
    applyWide("wide_sel11", 2'b11, 8'h88);

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: pending=%0d expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
